spi_dac_mc: RTL and testbench

// Parametrised multi-channel SPI DAC driver. It serialises N_CH DAC words in parallel, one MOSI line per channel,

---
 rtl/spi_dac_mc.sv | 225 ++++++++++++++++++++++
 tb/tb_spi_dac_mc.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dac_mc.sv
// spi_dac_mc: multi-channel SPI DAC driver.
// One MOSI line per channel, shared CS_n/SCK. Each channel word is
// {zero pad, command, data}, sent MSB first. Each channel is double-buffered:
// a staged register written by upd_i and a frame shadow loaded on accept.
module spi_dac_mc #(
  parameter int N_CH      = 2,
  parameter int DATA_W    = 12,
  parameter int CMD_W     = 2,
  parameter int FRAME_W   = 16,
  parameter int SCK_DIV   = 10,
  parameter int QUIET_CYC = 4,
  // A zero-width command field still needs a 1-bit port slice per channel.
  localparam int CMD_PW   = (CMD_W > 0) ? CMD_W : 1
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   start_i,
  input  logic [N_CH*DATA_W-1:0] data_i,
  input  logic [N_CH*CMD_PW-1:0] cmd_i,
  input  logic [N_CH-1:0]        upd_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   spi_cs_no,
  output logic                   spi_sck_o,
  output logic [N_CH-1:0]        spi_mosi_o
);

  localparam int PAD_W   = FRAME_W - CMD_W - DATA_W;
  // One counter times both SCK half-periods and the quiet gap.
  localparam int CNT_MAX = (SCK_DIV > QUIET_CYC) ? SCK_DIV : QUIET_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  if (PAD_W < 0) begin : g_chk_pad
    $error("spi_dac_mc: FRAME_W smaller than CMD_W + DATA_W");
  end
  if (SCK_DIV < 1) begin : g_chk_div
    $error("spi_dac_mc: SCK_DIV must be >= 1");
  end
  if (QUIET_CYC < 1) begin : g_chk_quiet
    $error("spi_dac_mc: QUIET_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PRE   = 3'd2,
    S_SH    = 3'd3,
    S_SL    = 3'd4,
    S_QUIET = 3'd5
  } state_e;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [BIT_W-1:0]             bit_q, bit_d;
  logic [N_CH-1:0][FRAME_W-1:0] shadow_q, shadow_d;
  logic [N_CH-1:0][DATA_W-1:0]  data_stg_q, data_stg_d;
  logic [N_CH-1:0][CMD_PW-1:0]  cmd_stg_q, cmd_stg_d;
  logic                         sck_q, sck_d;
  logic                         cs_q, cs_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         half_tc_s, quiet_tc_s;

  // Build the frame word {pad, cmd, data}; with no command field only data remains.
  function automatic logic [FRAME_W-1:0] frame_word(input logic [CMD_PW-1:0] cmd,
                                                    input logic [DATA_W-1:0] data);
    logic [FRAME_W-1:0] w;
    w = {FRAME_W{1'b0}};
    w[DATA_W-1:0] = data;
    w = (CMD_W > 0) ? (w | (FRAME_W'(cmd) << DATA_W)) : w;
    return w;
  endfunction

  // Staged registers follow upd_i in every state; the frame uses the shadow copy.
  always_comb begin
    data_stg_d = data_stg_q;
    cmd_stg_d  = cmd_stg_q;
    for (int k = 0; k < N_CH; k++) begin
      if (upd_i[k]) begin
        data_stg_d[k] = data_i[k*DATA_W +: DATA_W];
        cmd_stg_d[k]  = (CMD_W > 0) ? cmd_i[k*CMD_PW +: CMD_PW] : {CMD_PW{1'b0}};
      end else begin
        data_stg_d[k] = data_stg_q[k];
        cmd_stg_d[k]  = cmd_stg_q[k];
      end
    end
  end

  // Frame sequencer: next state, counters, shadow shifting and pin levels.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    shadow_d   = shadow_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    half_tc_s  = (cnt_q == CNT_W'(SCK_DIV - 1));
    quiet_tc_s = (cnt_q == CNT_W'(QUIET_CYC - 1));
    case (state_q)
      S_IDLE: begin
        if (start_i || en_i) begin
          // Shadow takes the staged value from before this edge.
          for (int k = 0; k < N_CH; k++) begin
            shadow_d[k] = frame_word(cmd_stg_q[k], data_stg_q[k]);
          end
          busy_d  = 1'b1;
          sck_d   = 1'b1;
          cs_d    = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_SETUP;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_SETUP: begin
        if (half_tc_s) begin
          sck_d   = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_PRE;
        end else begin
          state_d = S_SETUP;
        end
      end
      S_PRE: begin
        if (half_tc_s) begin
          cs_d    = 1'b0;
          sck_d   = 1'b1;
          bit_d   = {BIT_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_SH;
        end else begin
          state_d = S_PRE;
        end
      end
      S_SH: begin
        if (half_tc_s) begin
          sck_d   = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_SL;
        end else begin
          state_d = S_SH;
        end
      end
      S_SL: begin
        if (half_tc_s) begin
          cnt_d = {CNT_W{1'b0}};
          if (bit_q == BIT_W'(FRAME_W - 1)) begin
            cs_d    = 1'b1;
            state_d = S_QUIET;
          end else begin
            // MOSI moves only together with an SCK rising edge.
            sck_d = 1'b1;
            bit_d = bit_q + BIT_W'(1);
            for (int k = 0; k < N_CH; k++) begin
              shadow_d[k] = {shadow_q[k][FRAME_W-2:0], 1'b0};
            end
            state_d = S_SH;
          end
        end else begin
          state_d = S_SL;
        end
      end
      S_QUIET: begin
        if (quiet_tc_s) begin
          // busy stays high through the done cycle; IDLE clears it unless re-accepting.
          done_d  = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_IDLE;
        end else begin
          state_d = S_QUIET;
        end
      end
      default: begin
        state_d = S_IDLE;
        sck_d   = 1'b0;
        cs_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      bit_q      <= {BIT_W{1'b0}};
      shadow_q   <= {(N_CH*FRAME_W){1'b0}};
      data_stg_q <= {(N_CH*DATA_W){1'b0}};
      cmd_stg_q  <= {(N_CH*CMD_PW){1'b0}};
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shadow_q   <= shadow_d;
      data_stg_q <= data_stg_d;
      cmd_stg_q  <= cmd_stg_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Each MOSI pin is the MSB of its channel shadow register.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      spi_mosi_o[k] = shadow_q[k][FRAME_W-1];
    end
  end

  assign spi_sck_o = sck_q;
  assign spi_cs_no = cs_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_spi_dac_mc.sv
// Testbench for spi_dac_mc: default configuration plus a 4-channel, no-command,
// SCK_DIV=1 instance. Monitors reconstruct the words the DAC samples on each
// SCK falling edge and compare them against a scoreboard of expected words.
module tb_spi_dac_mc;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b0;
  logic        start_i = 1'b0;
  logic [23:0] data_i = 24'h0;
  logic [3:0]  cmd_i = 4'h0;
  logic [1:0]  upd_i = 2'b00;
  logic        busy_o, done_o, spi_cs_no, spi_sck_o;
  logic [1:0]  spi_mosi_o;

  logic        start2 = 1'b0;
  logic        en2 = 1'b0;
  logic [31:0] data2 = 32'h0;
  logic [3:0]  cmd2 = 4'h0;
  logic [3:0]  upd2 = 4'h0;
  logic        busy2, done2, cs2, sck2;
  logic [3:0]  mosi2;

  spi_dac_mc dut (
    .clk(clk), .rst_ni(rst_ni), .en_i(en_i), .start_i(start_i),
    .data_i(data_i), .cmd_i(cmd_i), .upd_i(upd_i),
    .busy_o(busy_o), .done_o(done_o), .spi_cs_no(spi_cs_no),
    .spi_sck_o(spi_sck_o), .spi_mosi_o(spi_mosi_o)
  );

  spi_dac_mc #(.N_CH(4), .DATA_W(8), .CMD_W(0), .FRAME_W(8), .SCK_DIV(1), .QUIET_CYC(4)) dut2 (
    .clk(clk), .rst_ni(rst_ni), .en_i(en2), .start_i(start2),
    .data_i(data2), .cmd_i(cmd2), .upd_i(upd2),
    .busy_o(busy2), .done_o(done2), .spi_cs_no(cs2),
    .spi_sck_o(sck2), .spi_mosi_o(mosi2)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] w1; logic [15:0] w0; } exp_t;
  typedef struct {
    logic [11:0] d0; logic [1:0] c0; logic [11:0] d1; logic [1:0] c1;
    logic [15:0] e0; logic [15:0] e1;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] sb2[$];
  vec_t        vecs[4];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor for the default instance.
  logic        in_f = 1'b0, cs_p = 1'b1, sck_p = 1'b0;
  int          rises = 0, t_fall = 0, t_rise = 0, t_acc = 0, cs_falls = 0, sck_edges = 0;
  logic [15:0] w0 = 16'h0, w1 = 16'h0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_ni) begin
      in_f  = 1'b0;
      cs_p  = 1'b1;
      sck_p = 1'b0;
    end else begin
      if (!sck_p && spi_sck_o && spi_cs_no) t_acc = cyc;
      if (sck_p != spi_sck_o) sck_edges++;
      if (cs_p && !spi_cs_no) begin
        in_f = 1'b1; rises = 0; w0 = 16'h0; w1 = 16'h0; t_fall = cyc; cs_falls++;
        check("cs_fall_after_accept", cyc - t_acc, 20);
      end
      if (in_f && !sck_p && spi_sck_o) rises++;
      if (in_f && sck_p && !spi_sck_o) begin
        w0 = {w0[14:0], spi_mosi_o[0]};
        w1 = {w1[14:0], spi_mosi_o[1]};
      end
      if (in_f && !cs_p && spi_cs_no) begin
        in_f = 1'b0; t_rise = cyc;
        check("sck_rises", rises, 16);
        check("cs_low_clks", cyc - t_fall, 320);
        check("frame_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("ch0_word", w0, mon_e.w0);
          check("ch1_word", w1, mon_e.w1);
        end
      end
      if (done_o) check("done_after_cs_rise", cyc - t_rise, 4);
      cs_p  = spi_cs_no;
      sck_p = spi_sck_o;
    end
  end

  // Monitor for the 4-channel instance.
  logic            in2 = 1'b0, cs2_p = 1'b1, sck2_p = 1'b0;
  int              rises2 = 0, t2 = 0;
  logic [3:0][7:0] w2 = 32'h0;

  always @(negedge clk) begin
    if (!rst_ni) begin
      in2    = 1'b0;
      cs2_p  = 1'b1;
      sck2_p = 1'b0;
    end else begin
      if (cs2_p && !cs2) begin in2 = 1'b1; rises2 = 0; w2 = 32'h0; t2 = cyc; end
      if (in2 && !sck2_p && sck2) rises2++;
      if (in2 && sck2_p && !sck2) begin
        for (int k = 0; k < 4; k++) w2[k] = {w2[k][6:0], mosi2[k]};
      end
      if (in2 && !cs2_p && cs2) begin
        in2 = 1'b0;
        check("p_sck_rises", rises2, 8);
        check("p_cs_low_clks", cyc - t2, 16);
        check("p_frame_expected", sb2.size() > 0, 1);
        if (sb2.size() > 0) check("p_words", w2, sb2.pop_front());
      end
      cs2_p  = cs2;
      sck2_p = sck2;
    end
  end

  task automatic push_exp(input logic [15:0] e0, input logic [15:0] e1);
    exp_t e;
    e.w0 = e0;
    e.w1 = e1;
    sb.push_back(e);
  endtask

  task automatic load(input logic [11:0] d0, input logic [1:0] c0,
                      input logic [11:0] d1, input logic [1:0] c1);
    data_i = {d1, d0};
    cmd_i  = {c1, c0};
    upd_i  = 2'b11;
    @(negedge clk);
    upd_i  = 2'b00;
  endtask

  task automatic start_frame(input logic [15:0] e0, input logic [15:0] e1);
    start_i = 1'b1;
    push_exp(e0, e1);
    @(negedge clk);
    start_i = 1'b0;
    check("accept_state", {busy_o, spi_sck_o, spi_cs_no}, 3'b111);
  endtask

  task automatic wait_done(input int budget);
    int   n;
    logic busy_ok;
    n = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!busy_o) busy_ok = 1'b0;
    end while (!done_o && n < budget);
    check("done_seen", done_o, 1'b1);
    check("busy_through_done", busy_ok, 1'b1);
  endtask

  task automatic finish_frame();
    wait_done(1000);
    @(negedge clk);
    check("idle_after_done", {busy_o, done_o}, 2'b00);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic no_new_frame(input string name);
    int f0;
    f0 = cs_falls;
    repeat (60) @(negedge clk);
    check(name, cs_falls - f0, 0);
  endtask

  initial begin
    int n;
    int e0;
    vecs[0] = '{12'hA5C, 2'b01, 12'h3F0, 2'b10, 16'h1A5C, 16'h23F0};
    vecs[1] = '{12'hFFF, 2'b11, 12'h000, 2'b00, 16'h3FFF, 16'h0000};
    vecs[2] = '{12'h800, 2'b01, 12'h001, 2'b10, 16'h1800, 16'h2001};
    vecs[3] = '{12'h123, 2'b11, 12'h7FF, 2'b00, 16'h3123, 16'h07FF};

    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("reset_outputs", {spi_cs_no, spi_sck_o, spi_mosi_o, busy_o, done_o}, 6'b100000);
    check("p_reset_outputs", {cs2, sck2, mosi2, busy2, done2}, 8'b10000000);

    // Table-driven single-shot frames.
    for (int i = 0; i < 4; i++) begin
      load(vecs[i].d0, vecs[i].c0, vecs[i].d1, vecs[i].c1);
      start_frame(vecs[i].e0, vecs[i].e1);
      finish_frame();
    end

    // Double buffer: update at bit 5 goes to the next frame.
    load(12'h111, 2'b01, 12'h0AB, 2'b10);
    start_frame(16'h1111, 16'h20AB);
    n = 0;
    while (!(in_f && rises >= 6) && n < 2000) begin @(negedge clk); n++; end
    check("reached_bit5", in_f && rises >= 6, 1'b1);
    data_i[11:0] = 12'h222;
    upd_i = 2'b01;
    @(negedge clk);
    upd_i = 2'b00;
    finish_frame();
    start_frame(16'h1222, 16'h20AB);
    finish_frame();
    // Same-cycle update and accept: old staged value is sent.
    data_i[11:0] = 12'h333;
    upd_i = 2'b01;
    start_frame(16'h1222, 16'h20AB);
    upd_i = 2'b00;
    finish_frame();
    start_frame(16'h1333, 16'h20AB);
    finish_frame();

    // Busy rule: start pulses during a frame are dropped.
    load(12'h456, 2'b00, 12'h789, 2'b11);
    start_frame(16'h0456, 16'h3789);
    repeat (40) @(negedge clk);
    pulse_start();
    repeat (150) @(negedge clk);
    pulse_start();
    finish_frame();
    no_new_frame("no_queued_start");
    check("sb_empty_busy", sb.size(), 0);

    // Continuous mode: three frames back to back, en dropped during the third.
    en_i = 1'b1;
    repeat (3) push_exp(16'h0456, 16'h3789);
    @(negedge clk);
    check("cont_accept", {busy_o, spi_sck_o, spi_cs_no}, 3'b111);
    wait_done(1000);
    @(negedge clk);
    check("cont_reaccept1", {busy_o, spi_sck_o, spi_cs_no}, 3'b111);
    wait_done(1000);
    @(negedge clk);
    check("cont_reaccept2", {busy_o, spi_sck_o, spi_cs_no}, 3'b111);
    n = 0;
    while (spi_cs_no && n < 100) begin @(negedge clk); n++; end
    en_i = 1'b0;
    wait_done(1000);
    @(negedge clk);
    check("cont_stop", {busy_o, done_o}, 2'b00);
    no_new_frame("no_frame4");
    check("sb_empty_cont", sb.size(), 0);

    // Asynchronous reset in the middle of SH while MOSI carries a 1.
    load(12'hFFF, 2'b11, 12'hFFF, 2'b11);
    start_frame(16'h3FFF, 16'h3FFF);
    n = 0;
    while (!(in_f && rises >= 5 && spi_sck_o) && n < 2000) begin @(negedge clk); n++; end
    check("mosi_high_before_reset", spi_mosi_o, 2'b11);
    #2 rst_ni = 1'b0;
    #1;
    check("async_reset", {spi_cs_no, spi_sck_o, spi_mosi_o, busy_o}, 5'b10000);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    #2 rst_ni = 1'b1;
    e0 = sck_edges;
    no_new_frame("no_cs_after_reset");
    check("no_sck_after_reset", sck_edges - e0, 0);
    // Staged registers were cleared by reset.
    start_frame(16'h0000, 16'h0000);
    finish_frame();

    // 4-channel instance, no command bits, 2-clk SCK period.
    for (int f = 0; f < 2; f++) begin
      data2 = (f == 0) ? 32'h813CF05A : 32'h01FF8000;
      upd2 = 4'hF;
      @(negedge clk);
      upd2 = 4'h0;
      start2 = 1'b1;
      sb2.push_back((f == 0) ? 32'h813CF05A : 32'h01FF8000);
      @(negedge clk);
      start2 = 1'b0;
      check("p_accept", {busy2, sck2, cs2}, 3'b111);
      n = 0;
      do begin @(negedge clk); n++; end while (!done2 && n < 200);
      check("p_done_seen", done2, 1'b1);
      @(negedge clk);
    end

    check("sb_drained", sb.size() + sb2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
